// File: rtl/tile_writeback_if.sv
// Tile-writeback bus: shader tile handshake, SRAM write port and status flags.
// slave is the writeback block's view, master is the environment's view.
interface tile_writeback_if #(
    parameter int unsigned NANO_DIM = 8,
    parameter int unsigned ADDR_W   = 20
);
    logic                             tile_valid;
    logic                             tile_ready;
    logic                             tile_id;
    logic [NANO_DIM*NANO_DIM*16-1:0]  tile_data;
    logic [9:0]                       tile_x;
    logic [9:0]                       tile_y;
    logic                             sram_req;
    logic                             sram_ack;
    logic [ADDR_W-1:0]                sram_addr;
    logic [15:0]                      sram_wdata;
    logic                             busy;
    logic                             done;
    logic                             done_id;

    modport slave (
        input  tile_valid, tile_id, tile_data, tile_x, tile_y, sram_ack,
        output tile_ready, sram_req, sram_addr, sram_wdata, busy, done, done_id
    );

    modport master (
        output tile_valid, tile_id, tile_data, tile_x, tile_y, sram_ack,
        input  tile_ready, sram_req, sram_addr, sram_wdata, busy, done, done_id
    );
endinterface

// File: rtl/tile_writeback.sv
// Captures a finished nano tile from the pixel shader and writes it pixel by
// pixel into the framebuffer through the SRAM arbiter, clipping pixels that
// fall outside the framebuffer.
// Optional: define TILE_WB_COLOR_KEY_EN to skip pixels equal to KEY_COLOR.
module tile_writeback #(
    parameter int unsigned NANO_DIM  = 8,
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter int unsigned ADDR_W    = 20,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic           BOARD_CLK,
    input  logic           RESET_N,
    tile_writeback_if.slave bus
);
    localparam int unsigned NPIX = NANO_DIM * NANO_DIM;
    localparam int unsigned CW   = (NANO_DIM > 1) ? $clog2(NANO_DIM) : 1;
    localparam int unsigned IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
`ifdef TILE_WB_COLOR_KEY_EN
    localparam bit KeyEn = 1'b1;
`else
    localparam bit KeyEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StAddr, StWrite, StNext, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              id_q, id_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [15:0]       pix_q [NPIX];

    logic              transfer;
    logic [IW-1:0]     idx;
    logic [15:0]       cur_pix;
    logic [10:0]       px, py;
    logic [31:0]       lin;
    logic              skip;

    assign transfer = bus.tile_valid && (state_q == StIdle);

    // Current pixel position and its framebuffer address; no wrap on the 11-bit sums.
    assign idx     = IW'(32'(row_q) * NANO_DIM + 32'(col_q));
    assign cur_pix = pix_q[idx];
    assign px      = 11'(x_q) + 11'(col_q);
    assign py      = 11'(y_q) + 11'(row_q);
    assign lin     = 32'(py) * FB_WIDTH + 32'(px);
    assign skip    = (32'(px) >= FB_WIDTH) || (32'(py) >= FB_HEIGHT) ||
                     (KeyEn && (cur_pix == KEY_COLOR));

    // Tile buffer: captured on handshake, frees the shader bank immediately.
    always_ff @(posedge BOARD_CLK) begin
        if (transfer) begin
            for (int i = 0; i < int'(NPIX); i++) begin
                pix_q[i] <= bus.tile_data[i*16 +: 16];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Next-state: walk the tile row-major, one SRAM write per unclipped pixel.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (bus.tile_valid) begin
                    id_d    = bus.tile_id;
                    x_d     = bus.tile_x;
                    y_d     = bus.tile_y;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (skip) begin
                    state_d = StNext;
                end else begin
                    addr_d  = lin[ADDR_W-1:0];
                    wdata_d = cur_pix;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (bus.sram_ack) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (col_q == CW'(NANO_DIM - 1)) begin
                    col_d = '0;
                    if (row_q == CW'(NANO_DIM - 1)) begin
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = StAddr;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StAddr;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.tile_ready = (state_q == StIdle);
    assign bus.sram_req   = (state_q == StWrite);
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.done_id    = (state_q == StDone) && id_q;

endmodule

// File: doc/tile_writeback.md
Name: tile_writeback

Overview:
- Consumes a finished nano tile (NANO_DIM x NANO_DIM RGB565 pixels) from the pixel shader's ping-pong tile banks and streams it, one pixel per SRAM transaction, into the framebuffer.
- Sits directly downstream of the pixel shader and upstream of the SRAM arbiter.
- Captures the tile into a local buffer on handshake, so the shader can immediately reuse that bank.

Parameters:
- NANO_DIM, 8, tile edge in pixels.
- FB_WIDTH, 640, framebuffer width in pixels (row pitch).
- FB_HEIGHT, 480, framebuffer height in pixels.
- ADDR_W, 20, SRAM word address width.
- KEY_COLOR, 16'hF81F, colour-key value (used only with optional feature).

Ports:
- BOARD_CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- tile_valid  in  1  shader has a finished tile on tile_data.
- tile_ready  out  1  block can accept a tile.
- tile_id  in  1  bank the tile came from (0/1); captured and echoed.
- tile_data  in  NANO_DIM*NANO_DIM*16  flattened tile; pixel (c,r) at bits [(r*NANO_DIM+c)*16 +: 16].
- tile_x, tile_y  in  10 each  framebuffer pixel coordinate of tile origin.
- sram_req  out  1  write request.
- sram_ack  in  1  arbiter accepted current write.
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  16  pixel data.
- busy  out  1  high from capture until done.
- done  out  1  one-cycle pulse after last pixel retired.
- done_id  out  1  tile_id of the tile just completed, valid with done.

Behaviour:
- Reset (async, RESET_N=0): state IDLE. tile_ready=1, sram_req=0, sram_addr=0, sram_wdata=0, busy=0, done=0, done_id=0. Column/row counters = 0. Tile buffer contents are don't-care.
- Handshake: transfer when tile_valid && tile_ready on a clock edge. On transfer, latch tile_data, tile_id, tile_x, tile_y. tile_ready drops the next cycle and stays low until back in IDLE.
- FSM:
  - IDLE: tile_ready=1. On transfer -> ADDR with col=row=0.
  - ADDR: compute px=tile_x+col and py=tile_y+row (11-bit unsigned, no wrap). If px>=FB_WIDTH or py>=FB_HEIGHT, the pixel is clipped -> NEXT. Otherwise register sram_addr=py*FB_WIDTH+px (truncated to ADDR_W) and sram_wdata=buffer pixel (col,row) -> WRITE.
  - WRITE: sram_req=1, addr/data held stable. When sram_ack=1 (same cycle or any later cycle), drop req the next cycle -> NEXT. sram_ack while not in WRITE is ignored.
  - NEXT: col+1. At col=NANO_DIM-1: col=0, row+1. After (NANO_DIM-1, NANO_DIM-1) -> DONE, otherwise -> ADDR.
  - DONE: done=1 and done_id=latched id for exactly one cycle, then -> IDLE.
- busy=1 in ADDR/WRITE/NEXT/DONE.
- Latency per written pixel: 3 cycles with ack in the first WRITE cycle (ADDR, WRITE, NEXT). Full unclipped 8x8 tile with zero-wait ack: 64*3+1 = 193 cycles from transfer to done.
- Pixel order is row-major, column fastest, matching the shader's tile layout.
- Fully clipped tile: no sram_req at all; done still pulses.
- tile_valid held high through DONE: a new transfer happens only in the first IDLE cycle after DONE. No back-to-back overlap.
- Reset mid-WRITE: req drops immediately (async). The in-flight pixel is abandoned and the tile is not completed; the arbiter must tolerate this.

Optional Feature:
- Macro TILE_WB_COLOR_KEY_EN.
- Defined: in ADDR, a pixel equal to KEY_COLOR is treated like a clipped pixel (skipped, no SRAM write), so the existing framebuffer content shows through.
- Undefined: every in-bounds pixel is written, including KEY_COLOR values. KEY_COLOR is unused.

Test Plan:
- Tile at (0,0), pixel(c,r)=r*8+c, ack tied high -> 64 writes, addr=r*640+c, data=r*8+c, done at cycle 193, done_id=tile_id.
- Tile at (636,100) -> only columns 0..3 written (32 writes), first addr=100*640+636, done still pulses.
- Tile at (0,476) -> rows 0..3 only (32 writes). Tile at (700,0) -> zero sram_req, done after 64*2+1=129 cycles.
- sram_ack delayed 5 cycles per write -> addr/data/req stable throughout each wait, 64 writes in order, no duplicates.
- tile_valid held high across two tiles with tile_id 0 then 1 -> second capture only after first done, done_id sequence 0,1.
- RESET_N pulsed low during the 10th WRITE -> req=0 immediately; after release tile_ready=1, and a new tile completes normally. With TILE_WB_COLOR_KEY_EN, a tile with 10 pixels = 16'hF81F -> 54 writes.
